mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: MIPS-style HI/LO multiply/divide unit with a fixed-latency busy window.
// Optional macro MDU_MADD_EN enables the accumulate ops (madd/maddu/msub/msubu, op 7-10).
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        busy_real,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;

  localparam logic [CW-1:0] MULT_CYC = CW'(5);
  localparam logic [CW-1:0] DIV_CYC  = CW'(10);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [3:0]      op_q;
  logic [W-1:0]    a_q, b_q;
  logic            is_launchable, launch, done;
  logic [2*W-1:0]  prod_s, prod_u;
  logic            signed_div;
  logic [W-1:0]    abs_a, abs_b, div_b, quo_u, rem_u, quo, rem;
  logic            wr_en;
  logic [W-1:0]    hi_nxt, lo_nxt;

  // Decode which op codes start a multi-cycle operation
  always_comb begin
    is_launchable = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_launchable = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_launchable = 1'b1;
`endif
      default: is_launchable = 1'b0;
    endcase
  end

  assign busy      = (state == S_BUSY);
  assign launch    = start && is_launchable && !busy;
  assign busy_real = (start && is_launchable) || busy;

  // State register and busy down-counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: load latency at launch, count down, complete when the count reaches 1
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (launch) begin
          state_nxt = S_BUSY;
          cnt_nxt   = (op == OP_DIV || op == OP_DIVU) ? DIV_CYC : MULT_CYC;
        end
      end
      S_BUSY: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Products and sign-magnitude division on the latched operands
  always_comb begin
    prod_s     = $signed({{W{a_q[W-1]}}, a_q}) * $signed({{W{b_q[W-1]}}, b_q});
    prod_u     = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    signed_div = (op_q == OP_DIV);
    abs_a      = (signed_div && a_q[W-1]) ? W'(-a_q) : a_q;
    abs_b      = (signed_div && b_q[W-1]) ? W'(-b_q) : b_q;
    div_b      = (abs_b == '0) ? W'(1) : abs_b;
    quo_u      = abs_a / div_b;
    rem_u      = abs_a % div_b;
    // 0x80000000 / -1 falls out naturally: |q| = 0x80000000, no negation
    quo        = (signed_div && (a_q[W-1] ^ b_q[W-1])) ? W'(-quo_u) : quo_u;
    rem        = (signed_div && a_q[W-1]) ? W'(-rem_u) : rem_u;
  end

  // HI/LO update: completion result, or mthi/mtlo while idle
  always_comb begin
    wr_en  = 1'b0;
    hi_nxt = HI;
    lo_nxt = LO;
    if (done) begin
      case (op_q)
        OP_MULT:  begin wr_en = 1'b1; {hi_nxt, lo_nxt} = prod_s; end
        OP_MULTU: begin wr_en = 1'b1; {hi_nxt, lo_nxt} = prod_u; end
        OP_DIV, OP_DIVU: begin
          if (b_q != '0) begin
            wr_en  = 1'b1;
            hi_nxt = rem;
            lo_nxt = quo;
          end
        end
`ifdef MDU_MADD_EN
        OP_MADD:  begin wr_en = 1'b1; {hi_nxt, lo_nxt} = {HI, LO} + prod_s; end
        OP_MADDU: begin wr_en = 1'b1; {hi_nxt, lo_nxt} = {HI, LO} + prod_u; end
        OP_MSUB:  begin wr_en = 1'b1; {hi_nxt, lo_nxt} = {HI, LO} - prod_s; end
        OP_MSUBU: begin wr_en = 1'b1; {hi_nxt, lo_nxt} = {HI, LO} - prod_u; end
`endif
        default: wr_en = 1'b0;
      endcase
    end else if (!busy && op == OP_MTHI) begin
      wr_en  = 1'b1;
      hi_nxt = A;
    end else if (!busy && op == OP_MTLO) begin
      wr_en  = 1'b1;
      lo_nxt = A;
    end
  end

  // Operand latch and HI/LO registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      HI   <= '0;
      LO   <= '0;
    end else begin
      if (launch) begin
        op_q <= op;
        a_q  <= A;
        b_q  <= B;
      end
      if (wr_en) begin
        HI <= hi_nxt;
        LO <= lo_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit; expected HI/LO results go through a scoreboard queue.
// Build with MDU_MADD_EN defined to check the accumulate ops instead of their no-op behaviour.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        busy, busy_real;
  logic [31:0] HI, LO;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb[$];
  logic [63:0] model_hl;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .busy_real(busy_real), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint sa, sbv;
    logic [63:0] r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      4'd1: r = 64'(sa * sbv);
      4'd2: r = {32'd0, a} * {32'd0, b};
      4'd3: r = (b == 32'd0) ? cur : {32'(sa % sbv), 32'(sa / sbv)};
      4'd4: r = (b == 32'd0) ? cur : {a % b, a / b};
      4'd7: r = cur + 64'(sa * sbv);
      4'd8: r = cur + {32'd0, a} * {32'd0, b};
      4'd9: r = cur - 64'(sa * sbv);
      4'd10: r = cur - {32'd0, a} * {32'd0, b};
      default: r = cur;
    endcase
    return r;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
  endtask

  // Launch one op, check busy window length, HI/LO hold, and the scoreboard result
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc);
    logic [63:0] exp;
    int n;
    sb.push_back(model(o, a, b, model_hl));
    start = 1'b1; op = o; A = a; B = b;
    #1;
    checks++;
    if (busy_real !== 1'b1) begin
      failures++; $display("FAIL %s busy_real at launch: got %b expected 1", name, busy_real);
    end
    tick();
    idle_inputs();
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      checks++;
      if ({HI, LO} !== model_hl) begin
        failures++; $display("FAIL %s hold during busy: got %h expected %h", name, {HI, LO}, model_hl);
      end
      n++;
      tick();
    end
    checks++;
    if (n != exp_cyc) begin
      failures++; $display("FAIL %s busy cycles: got %0d expected %0d", name, n, exp_cyc);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++; $display("FAIL %s scoreboard empty: got 0 entries expected 1", name);
    end else begin
      exp = sb.pop_front();
      if ({HI, LO} !== exp) begin
        failures++; $display("FAIL %s result: got %h expected %h", name, {HI, LO}, exp);
      end
      model_hl = exp;
    end
  endtask

  task automatic move_to(input string name, input logic [3:0] o, input logic [31:0] a);
    start = 1'b0; op = o; A = a; B = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    if (o == 4'd5) model_hl[63:32] = a;
    else model_hl[31:0] = a;
    checks++;
    if ({HI, LO} !== model_hl) begin
      failures++; $display("FAIL %s: got %h expected %h", name, {HI, LO}, model_hl);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1; op = 4'd1; A = 32'h7; B = 32'h9;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      failures++; $display("FAIL reset_state: got busy=%b HI=%h LO=%h expected 0 0 0", busy, HI, LO);
    end
    reset = 1'b1;
    idle_inputs();
    #1;
    checks++;
    if (busy_real !== 1'b0) begin
      failures++; $display("FAIL reset_busy_real: got %b expected 0", busy_real);
    end
    model_hl = 64'd0;
    tick();
  endtask

  task automatic test_mult();
    run_op("mult_spec", 4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 5);
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL mult_const: got %h_%h expected ffffffff_fffffffe", HI, LO);
    end
    run_op("multu_spec", 4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5);
    checks++;
    if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL multu_const: got %h_%h expected 00000001_fffffffe", HI, LO);
    end
    for (int i = 0; i < 4; i++) begin
      run_op("mult_rand", 4'd1, $urandom, $urandom, 5);
      run_op("multu_rand", 4'd2, $urandom, $urandom, 5);
    end
  endtask

  task automatic test_div();
    run_op("div_spec", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
    checks++;
    if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL div_const: got HI=%h LO=%h expected ffffffff fffffffd", HI, LO);
    end
    run_op("divu_spec", 4'd4, 32'd7, 32'd2, 10);
    checks++;
    if (LO !== 32'd3 || HI !== 32'd1) begin
      failures++; $display("FAIL divu_const: got HI=%h LO=%h expected 1 3", HI, LO);
    end
    run_op("div_overflow", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    checks++;
    if (LO !== 32'h8000_0000 || HI !== 32'd0) begin
      failures++; $display("FAIL div_overflow_const: got HI=%h LO=%h expected 0 80000000", HI, LO);
    end
    run_op("div_negdivisor", 4'd3, 32'd7, 32'hFFFF_FFFE, 10);
    for (int i = 0; i < 3; i++) begin
      run_op("div_rand", 4'd3, $urandom, $urandom_range(1, 1000), 10);
      run_op("divu_rand", 4'd4, $urandom, $urandom, 10);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] lo_before;
    move_to("mthi", 4'd5, 32'h1234_5678);
    lo_before = LO;
    run_op("div_by_zero", 4'd3, 32'd55, 32'd0, 10);
    checks++;
    if (HI !== 32'h1234_5678 || LO !== lo_before) begin
      failures++; $display("FAIL div_zero_const: got HI=%h LO=%h expected 12345678 %h", HI, LO, lo_before);
    end
    run_op("divu_by_zero", 4'd4, 32'd9, 32'd0, 10);
  endtask

  // Relaunch and mtlo during busy must be dropped
  task automatic test_ignore_busy();
    logic [63:0] exp;
    int n;
    exp = model(4'd1, 32'd1000, 32'hFFFF_FFF0, model_hl);
    sb.push_back(exp);
    start = 1'b1; op = 4'd1; A = 32'd1000; B = 32'hFFFF_FFF0;
    tick();
    idle_inputs();
    tick();
    start = 1'b1; op = 4'd2; A = 32'h0BAD_F00D; B = 32'h1234_5678;
    #1;
    checks++;
    if (busy_real !== 1'b1) begin
      failures++; $display("FAIL ignore busy_real: got %b expected 1", busy_real);
    end
    tick();
    start = 1'b0; op = 4'd6; A = 32'hCAFE_CAFE;
    tick();
    idle_inputs();
    n = 3;
    while (busy === 1'b1 && n < 20) begin n++; tick(); end
    checks++;
    if (n != 5) begin
      failures++; $display("FAIL ignore busy cycles: got %0d expected 5", n);
    end
    checks++;
    exp = sb.pop_front();
    if ({HI, LO} !== exp) begin
      failures++; $display("FAIL ignore result: got %h expected %h", {HI, LO}, exp);
    end
    model_hl = exp;
  endtask

  task automatic test_reset_abort();
    start = 1'b1; op = 4'd4; A = 32'd100; B = 32'd7;
    tick();
    idle_inputs();
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_hl = 64'd0;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      failures++; $display("FAIL abort_state: got busy=%b HI=%h LO=%h expected 0 0 0", busy, HI, LO);
    end
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      failures++; $display("FAIL abort_no_write: got busy=%b HI=%h LO=%h expected 0 0 0", busy, HI, LO);
    end
  endtask

  task automatic test_noop_ops();
    logic [3:0] nops[6];
    nops = '{4'd0, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    move_to("mtlo_pre", 4'd6, 32'h5555_AAAA);
    foreach (nops[i]) begin
      start = 1'b1; op = nops[i]; A = 32'h1111_2222; B = 32'h3;
      #1;
      checks++;
      if (busy_real !== 1'b0) begin
        failures++; $display("FAIL noop busy_real op=%0d: got %b expected 0", nops[i], busy_real);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || {HI, LO} !== model_hl) begin
        failures++; $display("FAIL noop state op=%0d: got busy=%b %h expected 0 %h", nops[i], busy, {HI, LO}, model_hl);
      end
    end
    idle_inputs();
  endtask

  task automatic test_madd();
    move_to("madd_hi0", 4'd5, 32'd0);
    move_to("madd_lo", 4'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("maddu_spec", 4'd8, 32'd1, 32'd1, 5);
    checks++;
    if (HI !== 32'd1 || LO !== 32'd0) begin
      failures++; $display("FAIL maddu_const: got HI=%h LO=%h expected 1 0", HI, LO);
    end
    run_op("madd", 4'd7, 32'hFFFF_FFFD, 32'd5, 5);
    run_op("msub", 4'd9, $urandom, $urandom, 5);
    run_op("msubu", 4'd10, $urandom, $urandom, 5);
`else
    for (int o = 7; o <= 10; o++) begin
      start = 1'b1; op = 4'(o); A = 32'd1; B = 32'd1;
      #1;
      checks++;
      if (busy_real !== 1'b0) begin
        failures++; $display("FAIL madd_disabled busy_real op=%0d: got %b expected 0", o, busy_real);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'hFFFF_FFFF) begin
        failures++; $display("FAIL madd_disabled state op=%0d: got busy=%b HI=%h LO=%h expected 0 0 ffffffff", o, busy, HI, LO);
      end
    end
    idle_inputs();
`endif
  endtask

  task automatic test_back_to_back();
    run_op("b2b_mult", 4'd1, 32'h8000_0000, 32'h8000_0000, 5);
    run_op("b2b_div", 4'd3, 32'h8000_0001, 32'd3, 10);
    run_op("b2b_multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    move_to("b2b_mthi", 4'd5, 32'hA5A5_5A5A);
    run_op("b2b_divu", 4'd4, 32'hFFFF_FFFF, 32'd16, 10);
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_hl = 64'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_busy();
    test_reset_abort();
    test_noop_ops();
    test_madd();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
